// File: rtl/prep5_div.sv
// Sequential restoring divider: one quotient bit per clock with a START/BUSY/DONE handshake.
// Defining DIV_BYZERO_FLAG_EN adds the DZ output, flagging a divide-by-zero result.
module prep5_div #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [VW-1:0] b,
    output logic [DW-1:0] q,
    output logic [VW-1:0] r,
    output logic          busy,
    output logic          done
`ifdef DIV_BYZERO_FLAG_EN
    ,
    output logic          dz
`endif
);

    localparam int CW = $clog2(DW + 1);
    localparam logic [CW-1:0] C_LAST = CW'(DW - 1);

    // ST_ZERO spends the single cycle before FIN that a zero divisor needs, without raising BUSY
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ZERO = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [DW-1:0]   d_r;
    logic [VW-1:0]   v_r;
    logic [VW:0]     p_r;
    logic [CW-1:0]   c_r;
    logic [DW-1:0]   q_r;
    logic [VW-1:0]   r_r;
    logic            busy_r;
    logic            done_r;
    logic            accept_s;
    logic            last_s;
    logic [VW+1:0]   shifted_s;
    logic [VW:0]     diff_s;
    logic            take_s;
    logic [VW:0]     p_step_s;
    logic [DW-1:0]   d_step_s;

    // Request acceptance and end-of-run detection
    always_comb begin
        accept_s = 1'b0;
        if ((state_r == ST_IDLE) || (state_r == ST_FIN)) begin
            accept_s = start;
        end else begin
            accept_s = 1'b0;
        end
        last_s = (c_r == C_LAST);
    end

    // One restoring step; the partial remainder stays below V, so its top bit never carries
    always_comb begin
        shifted_s = {p_r, d_r[DW-1]};
        diff_s    = shifted_s[VW:0] - {1'b0, v_r};
        take_s    = (shifted_s >= {2'b00, v_r});
        if (take_s) begin
            p_step_s = diff_s;
            d_step_s = {d_r[DW-2:0], 1'b1};
        end else begin
            p_step_s = shifted_s[VW:0];
            d_step_s = {d_r[DW-2:0], 1'b0};
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_FIN: begin
                if (accept_s) begin
                    if (b == {VW{1'b0}}) begin
                        state_next_s = ST_ZERO;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_next_s = ST_FIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_ZERO: state_next_s = ST_FIN;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register with BUSY/DONE decoded ahead into flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == ST_RUN);
            done_r  <= (state_next_s == ST_FIN);
        end
    end

    // Datapath: operand capture, iteration and result load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_r <= {DW{1'b0}};
            v_r <= {VW{1'b0}};
            p_r <= {(VW+1){1'b0}};
            c_r <= {CW{1'b0}};
            q_r <= {DW{1'b0}};
            r_r <= {VW{1'b0}};
        end else if (accept_s) begin
            d_r <= a;
            v_r <= b;
            p_r <= {(VW+1){1'b0}};
            c_r <= {CW{1'b0}};
        end else if (state_r == ST_RUN) begin
            d_r <= d_step_s;
            p_r <= p_step_s;
            c_r <= c_r + {{(CW-1){1'b0}}, 1'b1};
            if (last_s) begin
                q_r <= d_step_s;
                r_r <= p_step_s[VW-1:0];
            end else begin
                q_r <= q_r;
                r_r <= r_r;
            end
        end else if (state_r == ST_ZERO) begin
            q_r <= {DW{1'b1}};
            r_r <= {VW{1'b1}};
        end else begin
            q_r <= q_r;
            r_r <= r_r;
        end
    end

`ifdef DIV_BYZERO_FLAG_EN
    logic dz_r;

    // Divide-by-zero flag follows the same completion edges as Q/R
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dz_r <= 1'b0;
        end else if ((state_r == ST_RUN) && last_s) begin
            dz_r <= 1'b0;
        end else if (state_r == ST_ZERO) begin
            dz_r <= 1'b1;
        end else begin
            dz_r <= dz_r;
        end
    end

    assign dz = dz_r;
`endif

    assign q    = q_r;
    assign r    = r_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_prep5_div.sv
// Scoreboard bench for prep5_div (DW=8, VW=4): the driver queues expected results,
// and a negedge monitor checks each DONE against the queue, including timing and BUSY length.
module tb_prep5_div;
    localparam int DW = 8;
    localparam int VW = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          busy;
    logic          done;
`ifdef DIV_BYZERO_FLAG_EN
    logic          dz;
`endif

    prep5_div #(.DW(DW), .VW(VW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .done  (done)
`ifdef DIV_BYZERO_FLAG_EN
        ,
        .dz    (dz)
`endif
    );

    typedef struct packed {
        logic [DW-1:0] eq;
        logic [VW-1:0] er;
        logic          edz;
        logic [31:0]   dcyc;
        logic [31:0]   blen;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   busy_len = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per DONE cycle
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_len = 0;
        end else begin
            if (busy) busy_len++;
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1 with empty scoreboard, q=%0d r=%0d (t=%0t)", q, r, $time);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", 32'(q), 32'(e.eq));
                    chk("remainder", 32'(r), 32'(e.er));
                    chk("done_cycle", 32'(cyc), e.dcyc);
                    chk("busy_cycles", 32'(busy_len), e.blen);
`ifdef DIV_BYZERO_FLAG_EN
                    chk("dz_flag", 32'(dz), 32'(e.edz));
`endif
                end
                busy_len = 0;
            end
        end
    end

    task automatic push_exp(input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic edz,
                            input logic zero_div);
        exp_t e;
        e.eq   = eq;
        e.er   = er;
        e.edz  = edz;
        e.dcyc = zero_div ? 32'(cyc + 1) : 32'(cyc + DW);
        e.blen = zero_div ? 32'd0 : 32'(DW);
        sb.push_back(e);
    endtask

    // One-cycle START pulse; operands are scrambled right after the accepting edge
    task automatic issue(input logic [DW-1:0] av, input logic [VW-1:0] bv,
                         input logic [DW-1:0] eq, input logic [VW-1:0] er, input logic edz);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        push_exp(eq, er, edz, (bv == 4'd0));
        a = 8'hA5;
        b = 4'hC;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL done_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        start = 1'b0;
        a = 8'd0;
        b = 4'd0;
        #7;
        chk("reset_q", 32'(q), 32'd0);
        chk("reset_r", 32'(r), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
`ifdef DIV_BYZERO_FLAG_EN
        chk("reset_dz", 32'(dz), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("hold_q", 32'(q), 32'd28);
        chk("hold_r", 32'(r), 32'd4);

        issue(8'd255, 4'd15, 8'd17, 4'd0, 1'b0);
        wait_idle();
        issue(8'd0, 4'd5, 8'd0, 4'd0, 1'b0);
        wait_idle();

        issue(8'd9, 4'd0, 8'hFF, 4'hF, 1'b1);
        wait_idle();
        issue(8'd9, 4'd3, 8'd3, 4'd0, 1'b0);
        wait_idle();

        // START held high: the second request is taken in FIN with the operands present then
        @(negedge clk);
        a = 8'd100;
        b = 4'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        push_exp(8'd11, 4'd1, 1'b0, 1'b0);
        a = 8'd50;
        b = 4'd6;
        repeat (DW + 1) @(posedge clk);
        #1;
        chk("b2b_accept_cycle", 32'(cyc), 32'(k + DW + 1));
        push_exp(8'd8, 4'd2, 1'b0, 1'b0);
        start = 1'b0;
        wait_idle();

        // START during RUN is ignored
        issue(8'd77, 4'd5, 8'd15, 4'd2, 1'b0);
        @(negedge clk);
        a = 8'd1;
        b = 4'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // Reset during step 4 aborts without DONE
        @(negedge clk);
        a = 8'd99;
        b = 4'd4;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_q", 32'(q), 32'd0);
        chk("abort_r", 32'(r), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_idle_busy", 32'(busy), 32'd0);
        issue(8'd13, 4'd2, 8'd6, 4'd1, 1'b0);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
